// File: rtl/jt12_slotseq_pkg.sv
// Shared constants and slot-mapping helpers for the FM operator slot sequencer.
// Slots are packed as {op[1:0], ch[2:0]}.
package jt12_slotseq_pkg;

    localparam int SLOTS6 = 24;
    localparam int SLOTS3 = 12;
    localparam logic [4:0] LAST_SLOT6 = 5'b11110;
    localparam logic [4:0] LAST_SLOT3 = 5'b11010;

    // Same mapping as the next-slot adder: 6ch skips ch codes 3 and 7.
    function automatic logic [4:0] next_slot(input logic [4:0] slot, input int num_ch);
        logic [1:0] op;
        logic [2:0] ch;
        op = slot[4:3];
        ch = slot[2:0];
        if (num_ch == 3) begin
            if (ch >= 3'd2) begin
                ch = 3'd0;
                op = op + 2'd1;
            end else begin
                ch = ch + 3'd1;
            end
        end else begin
            if (ch >= 3'd6) begin
                ch = 3'd0;
                op = op + 2'd1;
            end else if (ch[1:0] == 2'd2) begin
                ch = ch + 3'd2;
            end else begin
                ch = ch + 3'd1;
            end
        end
        return {op, ch};
    endfunction

    function automatic logic [2:0] ch_linear(input logic [2:0] ch, input int num_ch);
        logic [2:0] lin;
        lin = {1'b0, ch[1:0]};
        if (num_ch != 3 && ch[2]) begin
            lin = lin + 3'd3;
        end
        return lin;
    endfunction

endpackage

// File: rtl/jt12_slotprev.sv
// Combinational predecessor of a packed slot: the exact inverse of next_slot().
module jt12_slotprev
    import jt12_slotseq_pkg::*;
#(
    parameter int num_ch = 6
) (
    input  logic [4:0] slot,
    output logic [4:0] prev_slot
);

    logic [1:0] op_p;
    logic [2:0] ch_p;

    always_comb begin
        op_p = slot[4:3];
        ch_p = slot[2:0];
        if (num_ch == 3) begin
            if (ch_p == 3'd0) begin
                ch_p = 3'd2;
                op_p = op_p - 2'd1;
            end else begin
                ch_p = ch_p - 3'd1;
            end
        end else begin
            // ch 0 comes from ch 6 of the previous operator; ch 4 follows ch 2.
            if (ch_p == 3'd0) begin
                ch_p = 3'd6;
                op_p = op_p - 2'd1;
            end else if (ch_p == 3'd4) begin
                ch_p = 3'd2;
            end else begin
                ch_p = ch_p - 3'd1;
            end
        end
        prev_slot = {op_p, ch_p};
    end

endmodule

// File: rtl/jt12_slotseq.sv
// Free-running FM slot sequencer: packed slot index plus registered per-slot decode.
// All outputs update together from the next-slot value, so decode adds no latency.
module jt12_slotseq
    import jt12_slotseq_pkg::*;
#(
    parameter int num_ch = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       sync_in,
    output logic [4:0] slot,
    output logic [2:0] ch_lin,
    output logic [1:0] op,
    output logic [3:0] op_oh,
    output logic [4:0] prev_slot,
    output logic       zero,
    output logic       sync_pend
);

    localparam logic [4:0] RST_PREV = (num_ch == 3) ? LAST_SLOT3 : LAST_SLOT6;

    logic [4:0] slot_q, slot_d;
    logic [2:0] ch_lin_q, ch_lin_d;
    logic [1:0] op_q, op_d;
    logic [3:0] op_oh_q, op_oh_d;
    logic [4:0] prev_q, prev_d;
    logic       zero_q, zero_d;
    logic       sync_pend_q, sync_pend_d;

    always_comb begin
        slot_d      = slot_q;
        zero_d      = 1'b0;
        sync_pend_d = sync_pend_q;
        if (cen) begin
            // A sync seen now or latched earlier restarts the cycle at slot 0.
            sync_pend_d = 1'b0;
            if (sync_in || sync_pend_q) begin
                slot_d = 5'd0;
            end else begin
                slot_d = next_slot(slot_q, num_ch);
            end
            zero_d = (slot_d == 5'd0);
        end else if (sync_in) begin
            sync_pend_d = 1'b1;
        end
        ch_lin_d = ch_linear(slot_d[2:0], num_ch);
        op_d     = slot_d[4:3];
        op_oh_d  = 4'b0001 << op_d;
    end

    jt12_slotprev #(
        .num_ch(num_ch)
    ) u_prev (
        .slot     (slot_d),
        .prev_slot(prev_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= 5'd0;
            ch_lin_q    <= 3'd0;
            op_q        <= 2'd0;
            op_oh_q     <= 4'b0001;
            prev_q      <= RST_PREV;
            zero_q      <= 1'b0;
            sync_pend_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            ch_lin_q    <= ch_lin_d;
            op_q        <= op_d;
            op_oh_q     <= op_oh_d;
            prev_q      <= prev_d;
            zero_q      <= zero_d;
            sync_pend_q <= sync_pend_d;
        end
    end

    assign slot      = slot_q;
    assign ch_lin    = ch_lin_q;
    assign op        = op_q;
    assign op_oh     = op_oh_q;
    assign prev_slot = prev_q;
    assign zero      = zero_q;
    assign sync_pend = sync_pend_q;

endmodule

// File: tb/tb_jt12_slotseq.sv
// Bench for jt12_slotseq: 6-channel and 3-channel instances share stimulus,
// each checked against an index-based reference model through an expected queue.
module tb_jt12_slotseq;

    logic clk;
    logic rst;
    logic cen;
    logic sync_in;

    logic [4:0] slot6, prev6, slot3, prev3;
    logic [2:0] ch_lin6, ch_lin3;
    logic [1:0] op6, op3;
    logic [3:0] op_oh6, op_oh3;
    logic       zero6, zero3, pend6, pend3;

    int checks;
    int errors;

    // expected vector: {slot, ch_lin, op, op_oh, prev_slot, zero, sync_pend}
    logic [20:0] exp_q6[$];
    logic [20:0] exp_q3[$];

    int  idx6, idx3;
    logic zr6, zr3, pd6, pd3;
    int  zero_cnt6;

    jt12_slotseq #(.num_ch(6)) dut6 (
        .clk(clk), .rst(rst), .cen(cen), .sync_in(sync_in),
        .slot(slot6), .ch_lin(ch_lin6), .op(op6), .op_oh(op_oh6),
        .prev_slot(prev6), .zero(zero6), .sync_pend(pend6)
    );

    jt12_slotseq #(.num_ch(3)) dut3 (
        .clk(clk), .rst(rst), .cen(cen), .sync_in(sync_in),
        .slot(slot3), .ch_lin(ch_lin3), .op(op3), .op_oh(op_oh3),
        .prev_slot(prev3), .zero(zero3), .sync_pend(pend3)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slot for position idx in the cycle: 6ch uses ch codes 0,1,2,4,5,6.
    function automatic logic [4:0] slot_of(input int idx, input int nch);
        int o;
        int c;
        logic [2:0] chf;
        o = idx / nch;
        c = idx % nch;
        chf = (nch == 6 && c >= 3) ? 3'(c + 1) : 3'(c);
        return {2'(o), chf};
    endfunction

    function automatic logic [20:0] expect_vec(input int idx, input int nch, input logic z, input logic p);
        int o;
        int c;
        int pidx;
        o = idx / nch;
        c = idx % nch;
        pidx = (idx == 0) ? (4 * nch - 1) : (idx - 1);
        return {slot_of(idx, nch), 3'(c), 2'(o), 4'(4'b0001 << o), slot_of(pidx, nch), z, p};
    endfunction

    task automatic model_step(input logic r, input logic c, input logic s, input int nch,
                              inout int idx, inout logic z, inout logic p);
        if (r) begin
            idx = 0;
            z   = 1'b0;
            p   = 1'b0;
        end else if (c) begin
            if (s || p) idx = 0;
            else idx = (idx + 1) % (4 * nch);
            z = (idx == 0);
            p = 1'b0;
        end else begin
            z = 1'b0;
            p = p | s;
        end
    endtask

    task automatic compare_outputs(input string name, input logic [20:0] e,
                                   input logic [4:0] s, input logic [2:0] cl, input logic [1:0] o,
                                   input logic [3:0] oh, input logic [4:0] pv, input logic z,
                                   input logic p);
        check_eq({name, ".slot"}, 32'(s), 32'(e[20:16]));
        check_eq({name, ".ch_lin"}, 32'(cl), 32'(e[15:13]));
        check_eq({name, ".op"}, 32'(o), 32'(e[12:11]));
        check_eq({name, ".op_oh"}, 32'(oh), 32'(e[10:7]));
        check_eq({name, ".prev_slot"}, 32'(pv), 32'(e[6:2]));
        check_eq({name, ".zero"}, 32'(z), 32'(e[1]));
        check_eq({name, ".sync_pend"}, 32'(p), 32'(e[0]));
    endtask

    // driver: one clock with given inputs; expectations pushed, then popped after the edge
    task automatic drive(input logic r, input logic c, input logic s);
        logic [20:0] e6;
        logic [20:0] e3;
        @(negedge clk);
        rst     = r;
        cen     = c;
        sync_in = s;
        model_step(r, c, s, 6, idx6, zr6, pd6);
        model_step(r, c, s, 3, idx3, zr3, pd3);
        exp_q6.push_back(expect_vec(idx6, 6, zr6, pd6));
        exp_q3.push_back(expect_vec(idx3, 3, zr3, pd3));
        @(posedge clk);
        #1;
        e6 = exp_q6.pop_front();
        e3 = exp_q3.pop_front();
        compare_outputs("ch6", e6, slot6, ch_lin6, op6, op_oh6, prev6, zero6, pend6);
        compare_outputs("ch3", e3, slot3, ch_lin3, op3, op_oh3, prev3, zero3, pend3);
        if (zero6) zero_cnt6++;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        idx6      = 0;
        idx3      = 0;
        zr6       = 1'b0;
        zr3       = 1'b0;
        pd6       = 1'b0;
        pd3       = 1'b0;
        zero_cnt6 = 0;
        rst       = 1'b1;
        cen       = 1'b0;
        sync_in   = 1'b0;

        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        check_eq("rst.prev6", 32'(prev6), 32'h1e);
        check_eq("rst.prev3", 32'(prev3), 32'h1a);

        // full cycle: 24 enables, one zero pulse on the last
        zero_cnt6 = 0;
        for (int i = 0; i < 24; i++) drive(1'b0, 1'b1, 1'b0);
        check_eq("wrap.slot6", 32'(slot6), 32'h00);
        check_eq("wrap.zero_cnt6", 32'(zero_cnt6), 32'd1);

        // advance to slot 05, then hold with cen low
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0);
        check_eq("hold.at05", 32'(slot6), 32'h05);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        check_eq("hold.next06", 32'(slot6), 32'h06);

        // to slot 0D, then sync with cen low (repeated) and apply on next cen
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0);
        check_eq("sync.at0d", 32'(slot6), 32'h0d);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        check_eq("sync.applied", 32'(slot6), 32'h00);

        // to slot 14, then sync with cen high
        for (int i = 0; i < 15; i++) drive(1'b0, 1'b1, 1'b0);
        check_eq("sync.at14", 32'(slot6), 32'h14);
        drive(1'b0, 1'b1, 1'b1);
        // sync while already at slot 0
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        check_eq("sync.restart", 32'(slot6), 32'h01);

        // random traffic with rare sync
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end

        // pending sync discarded by reset
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        check_eq("rstpend.slot6", 32'(slot6), 32'h01);
        check_eq("rstpend.zero6", 32'(zero6), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
